// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode and FSM encodings plus the
// opcode legality check. ALU_MUL_EN enables the iterative multiplier.
package alu_pkg;

    typedef enum logic [3:0] {
        OpSub  = 4'b0000,
        OpAnd  = 4'b0001,
        OpXor  = 4'b0010,
        OpOr   = 4'b0011,
        OpSll  = 4'b0100,
        OpSrl  = 4'b0101,
        OpSra  = 4'b0110,
        OpAdd  = 4'b0111,
        OpSlt  = 4'b1000,
        OpSltu = 4'b1001,
        OpMul  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_WAIT = 2'd2
    } alu_state_e;

    // MUL is only legal when the multiplier is built in.
    function automatic logic is_legal_op(alu_op_e op);
        logic legal;
        case (op)
            OpSub, OpAnd, OpXor, OpOr, OpSll, OpSrl, OpSra, OpAdd, OpSlt, OpSltu:
                legal = 1'b1;
`ifdef ALU_MUL_EN
            OpMul:   legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
        is_legal_op = legal;
    endfunction

endpackage

// File: rtl/alu_pipelined_if.sv
// Operation/result handshake bundle for the pipelined ALU.
// slave: the ALU side; master: the issuing/consuming side.
interface alu_pipelined_if #(
    parameter int unsigned XLEN = 64
);
    logic            valid_in;
    logic            ready_out;
    logic [XLEN-1:0] operand1_in;
    logic [XLEN-1:0] operand2_in;
    logic [3:0]      aluOpcode_in;
    logic            valid_out;
    logic            ready_in;
    logic [XLEN-1:0] result_out;
    logic            zeroFlag_out;
    logic            illegal_out;

    modport master (
        output valid_in, operand1_in, operand2_in, aluOpcode_in, ready_in,
        input  ready_out, valid_out, result_out, zeroFlag_out, illegal_out
    );

    modport slave (
        input  valid_in, operand1_in, operand2_in, aluOpcode_in, ready_in,
        output ready_out, valid_out, result_out, zeroFlag_out, illegal_out
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-and-add multiplier, one multiplier bit per cycle, always
// XLEN steps. Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            start_in,
    input  logic [XLEN-1:0] multiplicand_in,
    input  logic [XLEN-1:0] multiplier_in,
    output logic            done_out,
    output logic [XLEN-1:0] product_out
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    logic            r_busy;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;

    // Load on start, then one add/shift step per cycle for the full count.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start_in) begin
            r_busy   <= 1'b1;
            r_count  <= CNT_W'(XLEN);
            r_acc    <= '0;
            r_mcand  <= multiplicand_in;
            r_mplier <= multiplier_in;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - 1'b1;
            if (r_count == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // High during the final step; product_out is complete after that edge.
    assign done_out    = r_busy && (r_count == CNT_W'(1));
    assign product_out = r_acc;

endmodule

// File: rtl/alu_pipelined.sv
// Registered ALU with valid/ready handshake, zero and illegal-opcode flags.
// Define ALU_MUL_EN to add the iterative multiplier (opcode 1010) and the
// MUL_BUSY/MUL_WAIT states; otherwise MUL is treated as illegal.
module alu_pipelined
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic          clk_in,
    input  logic          reset_in,
    alu_pipelined_if.slave alu_bus
);
    localparam int unsigned SHAMT_W = $clog2(XLEN);

    alu_op_e              w_op;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_legal;
    logic                 w_slot_free;
    logic                 w_ready;
    logic                 w_accept;
    logic [XLEN-1:0]      w_alu_res;
    logic [XLEN-1:0]      w_single_res;
    logic                 w_load;
    logic [XLEN-1:0]      w_load_val;
    logic                 w_load_ill;

    logic                 r_valid;
    logic [XLEN-1:0]      r_result;
    logic                 r_zero;
    logic                 r_illegal;

    assign w_op        = alu_op_e'(alu_bus.aluOpcode_in);
    assign w_shamt     = alu_bus.operand2_in[SHAMT_W-1:0];
    assign w_legal     = is_legal_op(w_op);
    assign w_slot_free = !r_valid || alu_bus.ready_in;
    assign w_accept    = alu_bus.valid_in && w_ready;

    // Single-cycle datapath; MUL and illegal codes fall through to zero.
    always_comb begin
        w_alu_res = '0;
        case (w_op)
            OpSub:   w_alu_res = alu_bus.operand1_in - alu_bus.operand2_in;
            OpAnd:   w_alu_res = alu_bus.operand1_in & alu_bus.operand2_in;
            OpXor:   w_alu_res = alu_bus.operand1_in ^ alu_bus.operand2_in;
            OpOr:    w_alu_res = alu_bus.operand1_in | alu_bus.operand2_in;
            OpSll:   w_alu_res = alu_bus.operand1_in << w_shamt;
            OpSrl:   w_alu_res = alu_bus.operand1_in >> w_shamt;
            OpSra:   w_alu_res = $unsigned($signed(alu_bus.operand1_in) >>> w_shamt);
            OpAdd:   w_alu_res = alu_bus.operand1_in + alu_bus.operand2_in;
            OpSlt:   w_alu_res = {{(XLEN-1){1'b0}},
                                  $signed(alu_bus.operand1_in) < $signed(alu_bus.operand2_in)};
            OpSltu:  w_alu_res = {{(XLEN-1){1'b0}},
                                  alu_bus.operand1_in < alu_bus.operand2_in};
            default: w_alu_res = '0;
        endcase
    end

    assign w_single_res = w_legal ? w_alu_res : '0;

`ifdef ALU_MUL_EN
    alu_state_e      r_state;
    alu_state_e      w_state_next;
    logic            w_mul_start;
    logic            w_mul_done;
    logic            w_load_mul;
    logic [XLEN-1:0] w_mul_product;

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; MUL_WAIT holds the product until the output slot frees up.
    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        w_load_mul   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (w_op == OpMul)) begin
                    w_mul_start  = 1'b1;
                    w_state_next = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (w_mul_done) begin
                    w_state_next = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (w_slot_free) begin
                    w_load_mul   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    alu_mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .start_in        (w_mul_start),
        .multiplicand_in (alu_bus.operand1_in),
        .multiplier_in   (alu_bus.operand2_in),
        .done_out        (w_mul_done),
        .product_out     (w_mul_product)
    );

    assign w_ready    = (r_state == IDLE) && w_slot_free;
    assign w_load     = (w_accept && (w_op != OpMul)) || w_load_mul;
    assign w_load_val = w_load_mul ? w_mul_product : w_single_res;
    assign w_load_ill = w_load_mul ? 1'b0 : !w_legal;
`else
    assign w_ready    = w_slot_free;
    assign w_load     = w_accept;
    assign w_load_val = w_single_res;
    assign w_load_ill = !w_legal;
`endif

    // Output registers: load a new result, else drain when the consumer takes it.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_result  <= w_load_val;
            r_zero    <= (w_load_val == '0);
            r_illegal <= w_load_ill;
        end else if (alu_bus.ready_in) begin
            r_valid   <= 1'b0;
        end
    end

    assign alu_bus.ready_out    = w_ready;
    assign alu_bus.valid_out    = r_valid;
    assign alu_bus.result_out   = r_result;
    assign alu_bus.zeroFlag_out = r_zero;
    assign alu_bus.illegal_out  = r_illegal;

endmodule
